// File: rtl/wb_grf_if.sv
// W-stage bundle into the register file, plus the D-stage read ports and the
// forwarding/commit-log outputs that come back from it.
interface wb_grf_if;
    logic [31:0] Instr_W;
    logic [31:0] pc_W;
    logic [31:0] pc4_W;
    logic [31:0] outC_W;
    logic [31:0] ReadData_W;
    logic [3:0]  Tnew_W;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] RD1;
    logic [31:0] RD2;
    logic [4:0]  WA_W;
    logic [31:0] WD_W;
    logic        WE_W;
    logic        fwd_ready_W;
    logic        log_valid;
    logic [31:0] log_pc;
    logic [4:0]  log_reg;
    logic [31:0] log_data;
    logic [31:0] write_count;

    modport master (
        output Instr_W, pc_W, pc4_W, outC_W, ReadData_W, Tnew_W, A1, A2,
        input  RD1, RD2, WA_W, WD_W, WE_W, fwd_ready_W,
        input  log_valid, log_pc, log_reg, log_data, write_count
    );

    modport slave (
        input  Instr_W, pc_W, pc4_W, outC_W, ReadData_W, Tnew_W, A1, A2,
        output RD1, RD2, WA_W, WD_W, WE_W, fwd_ready_W,
        output log_valid, log_pc, log_reg, log_data, write_count
    );
endinterface

// File: rtl/wb_grf.sv
// Writeback stage: decodes the W-stage instruction, commits into the 32x32
// register file, serves two D-stage reads with W->D bypass, and logs commits.
module wb_grf #(
    parameter logic [31:0] LINK_OFFSET = 32'd8,
    parameter bit          LOG_EN      = 1'b1
) (
    input logic     clk,
    input logic     reset,
    wb_grf_if.slave bus
);

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] FN_ADD     = 6'b100000;
    localparam logic [5:0] FN_SUB     = 6'b100010;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  dec_dest;
    logic [31:0] dec_data;
    logic        we_w;
    logic [4:0]  wa_w;
    logic [31:0] wd_w;

    logic [31:0] grf_q [1:31];
    logic        log_valid_q;
    logic [31:0] log_pc_q;
    logic [4:0]  log_reg_q;
    logic [31:0] log_data_q;
    logic [31:0] write_count_q;
    logic [31:0] write_count_d;

    assign op    = bus.Instr_W[31:26];
    assign funct = bus.Instr_W[5:0];

    always_comb begin
        dec_dest = 5'd0;
        dec_data = 32'd0;
        case (op)
            OP_SPECIAL: begin
                if (funct == FN_ADD || funct == FN_SUB) begin
                    dec_dest = bus.Instr_W[15:11];
                    dec_data = bus.outC_W;
                end
            end
            OP_ORI, OP_LUI: begin
                dec_dest = bus.Instr_W[20:16];
                dec_data = bus.outC_W;
            end
            OP_LW: begin
                dec_dest = bus.Instr_W[20:16];
                dec_data = bus.ReadData_W;
            end
            OP_JAL: begin
                dec_dest = 5'd31;
                dec_data = bus.pc_W + LINK_OFFSET;
            end
            default: begin
                dec_dest = 5'd0;
                dec_data = 32'd0;
            end
        endcase
    end

    // A $0 destination is treated exactly like a non-writing instruction.
    assign we_w = (dec_dest != 5'd0);
    assign wa_w = dec_dest;
    assign wd_w = we_w ? dec_data : 32'd0;

    assign bus.WA_W        = wa_w;
    assign bus.WD_W        = wd_w;
    assign bus.WE_W        = we_w;
    assign bus.fwd_ready_W = we_w && (bus.Tnew_W == 4'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 1; i < 32; i++) begin
                grf_q[i] <= 32'd0;
            end
        end else if (we_w) begin
            grf_q[wa_w] <= wd_w;
        end
    end

    // Read ports: $0 is hard zero, then a same-cycle W write wins over the array.
    logic [4:0]  rd_addr [2];
    logic [31:0] rd_data [2];
    assign rd_addr[0] = bus.A1;
    assign rd_addr[1] = bus.A2;

    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
        always_comb begin
            rd_data[gi] = 32'd0;
            if (rd_addr[gi] == 5'd0) begin
                rd_data[gi] = 32'd0;
            end else if (we_w && (rd_addr[gi] == wa_w)) begin
                rd_data[gi] = wd_w;
            end else begin
                rd_data[gi] = grf_q[rd_addr[gi]];
            end
        end
    end

    assign bus.RD1 = rd_data[0];
    assign bus.RD2 = rd_data[1];

    assign write_count_d = write_count_q + 32'd1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            log_valid_q   <= 1'b0;
            log_pc_q      <= 32'd0;
            log_reg_q     <= 5'd0;
            log_data_q    <= 32'd0;
            write_count_q <= 32'd0;
        end else begin
            log_valid_q <= we_w;
            if (we_w) begin
                log_pc_q      <= bus.pc_W;
                log_reg_q     <= wa_w;
                log_data_q    <= wd_w;
                write_count_q <= write_count_d;
            end
        end
    end

    assign bus.log_valid   = LOG_EN ? log_valid_q : 1'b0;
    assign bus.log_pc      = LOG_EN ? log_pc_q    : 32'd0;
    assign bus.log_reg     = LOG_EN ? log_reg_q   : 5'd0;
    assign bus.log_data    = LOG_EN ? log_data_q  : 32'd0;
    assign bus.write_count = write_count_q;

    // pc+4 and the rs/shamt fields are carried in the bundle but not needed here.
    logic unused_bits;
    assign unused_bits = ^{bus.pc4_W, bus.Instr_W[25:21], bus.Instr_W[10:6]};

endmodule

// File: tb/tb_wb_grf.sv
// Self-checking bench for wb_grf: table-driven W-stage stimulus, a register
// file model for reads, and a queue scoreboard for the commit log.
module tb_wb_grf;

    logic clk;
    logic reset;
    wb_grf_if bif ();

    wb_grf #(.LINK_OFFSET(32'd8), .LOG_EN(1'b1)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  r;
        logic [31:0] d;
    } log_t;

    log_t        exp_q [$];
    logic [31:0] mem_m [32];
    logic [31:0] exp_count;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Log scoreboard: every log_valid pulse must match the oldest pending commit.
    always @(negedge clk) begin
        if (bif.log_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("log_unexpected", 32'd1, 32'd0);
            end else begin
                log_t e;
                e = exp_q.pop_front();
                check_eq("log_pc", bif.log_pc, e.pc);
                check_eq("log_reg", {27'd0, bif.log_reg}, {27'd0, e.r});
                check_eq("log_data", bif.log_data, e.d);
            end
        end
    end

    function automatic logic [31:0] model_rd(input logic [4:0] a, input logic [4:0] wa, input logic [31:0] wd);
        if (a == 5'd0) return 32'd0;
        if (wa != 5'd0 && a == wa) return wd;
        return mem_m[a];
    endfunction

    task automatic step(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] outc,
                        input logic [31:0] rdata, input logic [3:0] tnew,
                        input logic [4:0] ewa, input logic [31:0] ewd,
                        input logic [4:0] a1, input logic [4:0] a2);
        logic exp_lv;
        bif.Instr_W    = instr;
        bif.pc_W       = pc;
        bif.pc4_W      = pc + 32'd4;
        bif.outC_W     = outc;
        bif.ReadData_W = rdata;
        bif.Tnew_W     = tnew;
        bif.A1         = a1;
        bif.A2         = a2;
        #1;
        check_eq("WA_W", {27'd0, bif.WA_W}, {27'd0, ewa});
        check_eq("WE_W", {31'd0, bif.WE_W}, {31'd0, (ewa != 5'd0)});
        if (ewa != 5'd0) check_eq("WD_W", bif.WD_W, ewd);
        check_eq("fwd_ready_W", {31'd0, bif.fwd_ready_W}, {31'd0, (ewa != 5'd0 && tnew == 4'd0)});
        check_eq("RD1_bypass", bif.RD1, model_rd(a1, ewa, ewd));
        check_eq("RD2_bypass", bif.RD2, model_rd(a2, ewa, ewd));
        if (reset && ewa != 5'd0) exp_q.push_back('{pc: pc, r: ewa, d: ewd});

        @(posedge clk);
        #1;
        if (!reset) begin
            for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;
            exp_count = 32'd0;
            exp_lv    = 1'b0;
        end else if (ewa != 5'd0) begin
            mem_m[ewa] = ewd;
            exp_count  = exp_count + 32'd1;
            exp_lv     = 1'b1;
        end else begin
            exp_lv = 1'b0;
        end
        check_eq("log_valid", {31'd0, bif.log_valid}, {31'd0, exp_lv});
        check_eq("write_count", bif.write_count, exp_count);
        // Remove the writer so reads come from the array, not the bypass.
        bif.Instr_W = 32'd0;
        #1;
        check_eq("RD1_array", bif.RD1, model_rd(a1, 5'd0, 32'd0));
        check_eq("RD2_array", bif.RD2, model_rd(a2, 5'd0, 32'd0));
        $display("txn instr=0x%08h rst=%0b wa=%0d wd=0x%08h rd1=0x%08h rd2=0x%08h cnt=%0d",
                 instr, reset, ewa, ewd, bif.RD1, bif.RD2, bif.write_count);
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] outc;
        logic [31:0] rdata;
        logic [3:0]  tnew;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic [4:0]  a1;
        logic [4:0]  a2;
    } stim_t;

    stim_t stim [] = '{
        '{32'h34011234, 32'h00003000, 32'h00001234, 32'h0,        4'd0,  5'd1,  32'h00001234, 5'd1,  5'd0},  // ori $1
        '{32'h8C0A0000, 32'h00003004, 32'h0000AAAA, 32'hDEADBEEF, 4'd1,  5'd10, 32'hDEADBEEF, 5'd10, 5'd1},  // lw $10
        '{32'h0C000100, 32'h00003000, 32'h00000000, 32'h0,        4'd0,  5'd31, 32'h00003008, 5'd0,  5'd31}, // jal
        '{32'h00220020, 32'h0000300C, 32'h00000055, 32'h0,        4'd0,  5'd0,  32'h0,        5'd0,  5'd1},  // add $0
        '{32'hAC010000, 32'h00003010, 32'h00000000, 32'h0,        4'd0,  5'd0,  32'h0,        5'd1,  5'd10}, // sw
        '{32'h10220003, 32'h00003014, 32'h00000000, 32'h0,        4'd0,  5'd0,  32'h0,        5'd31, 5'd1},  // beq
        '{32'h03E00008, 32'h00003018, 32'h00000000, 32'h0,        4'd0,  5'd0,  32'h0,        5'd31, 5'd10}, // jr
        '{32'h00000000, 32'h0000301C, 32'h00000000, 32'h0,        4'd0,  5'd0,  32'h0,        5'd2,  5'd1},  // nop
        '{32'hFC000000, 32'h00003020, 32'h12345678, 32'h9ABCDEF0, 4'd0,  5'd0,  32'h0,        5'd1,  5'd2},  // undefined op
        '{32'h00221820, 32'h00003024, 32'h00001111, 32'h0,        4'd0,  5'd3,  32'h00001111, 5'd3,  5'd4},  // add $3
        '{32'h00222022, 32'h00003028, 32'h00002222, 32'h0,        4'd2,  5'd4,  32'h00002222, 5'd3,  5'd4},  // sub $4
        '{32'h3C07ABCD, 32'h0000302C, 32'hABCD0000, 32'h0,        4'd0,  5'd7,  32'hABCD0000, 5'd7,  5'd1}   // lui $7
    };

    initial begin
        reset            = 1'b0;
        bif.Instr_W      = 32'd0;
        bif.pc_W         = 32'd0;
        bif.pc4_W        = 32'd0;
        bif.outC_W       = 32'd0;
        bif.ReadData_W   = 32'd0;
        bif.Tnew_W       = 4'd0;
        bif.A1           = 5'd0;
        bif.A2           = 5'd0;
        exp_count        = 32'd0;
        for (int i = 0; i < 32; i++) mem_m[i] = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check_eq("rst_log_valid", {31'd0, bif.log_valid}, 32'd0);
        check_eq("rst_write_count", bif.write_count, 32'd0);
        check_eq("rst_log_pc", bif.log_pc, 32'd0);
        for (int a = 1; a < 32; a++) begin
            bif.A1 = 5'(a);
            bif.A2 = 5'(32 - a);
            #0.1;
            check_eq("rst_RD1", bif.RD1, 32'd0);
            check_eq("rst_RD2", bif.RD2, 32'd0);
        end
        $display("txn reset sweep done cnt=%0d", bif.write_count);
        @(posedge clk);
        #1;

        foreach (stim[k]) begin
            step(stim[k].instr, stim[k].pc, stim[k].outc, stim[k].rdata, stim[k].tnew,
                 stim[k].ewa, stim[k].ewd, stim[k].a1, stim[k].a2);
        end

        // Commit presented during reset is discarded; releasing reset lets it through.
        reset = 1'b0;
        step(32'h34050077, 32'h00003030, 32'h00000077, 32'h0, 4'd0, 5'd5, 32'h00000077, 5'd5, 5'd1);
        reset = 1'b1;
        step(32'h00000000, 32'h00003034, 32'h0, 32'h0, 4'd0, 5'd0, 32'h0, 5'd10, 5'd31);
        step(32'h34050077, 32'h00003030, 32'h00000077, 32'h0, 4'd0, 5'd5, 32'h00000077, 5'd5, 5'd1);

        bif.Instr_W = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("log_q_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
